// File: rtl/core_mem_arb.sv
// Merges the core's instruction-fetch and data ports onto one req/gnt/rvalid memory port.
// Accepted transactions are tracked in an ID FIFO so that in-order responses reach their issuer.
module core_mem_arb #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int PRIO_MODE       = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic [3:0]  outstanding_o,
    output logic        rsp_orphan_o
);

    localparam int         PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_I,
        ARB_WAIT_D
    } arb_state_t;

    arb_state_t       state;
    logic             rr_last;      // master granted most recently: 1 = data, 0 = instr
    logic [3:0]       count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             id_mem [MAX_OUTSTANDING];

    logic sel_data;
    logic sel_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_data;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sel_data = 1'b0;
        sel_req  = 1'b0;
        case (state)
            ARB_WAIT_I: begin
                sel_data = 1'b0;
                sel_req  = instr_req_i;
            end
            ARB_WAIT_D: begin
                sel_data = 1'b1;
                sel_req  = data_req_i;
            end
            default: begin
                sel_req = instr_req_i | data_req_i;
                if (instr_req_i && data_req_i)
                    sel_data = (PRIO_MODE == 0) ? 1'b1 : ~rr_last;
                else
                    sel_data = data_req_i;
            end
        endcase
    end

    assign full  = (count == MAX_CNT);
    assign empty = (count == 4'd0);

    // A full FIFO blocks new requests even when a pop lands in the same cycle.
    assign mem_req_o   = sel_req & ~full & ~rst;
    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & ~sel_data;
    assign data_gnt_o  = push & sel_data;

    assign mem_we_o    = sel_data & data_we_i;
    assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
    assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = sel_data ? data_wdata_i : 32'd0;

    assign pop            = mem_rvalid_i & ~empty & ~rst;
    assign head_data      = id_mem[rd_ptr];
    assign instr_rvalid_o = pop & ~head_data;
    assign data_rvalid_o  = pop & head_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;

    assign outstanding_o  = count;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            rr_last      <= 1'b0;
            count        <= 4'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rsp_orphan_o <= 1'b0;
        end else begin
            rsp_orphan_o <= mem_rvalid_i & empty;
            count        <= count + {3'b000, push} - {3'b000, pop};
            if (push) begin
                wr_ptr  <= ptr_next(wr_ptr);
                rr_last <= sel_data;
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);

            case (state)
                ARB_IDLE: begin
                    if (mem_req_o && !mem_gnt_i)
                        state <= sel_data ? ARB_WAIT_D : ARB_WAIT_I;
                end
                ARB_WAIT_I, ARB_WAIT_D: begin
                    // Leave on the grant, or when the locked master abandons its request.
                    if (push || !sel_req)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // NOTE: the ID storage has no reset; only entries between the reset pointers are ever read.
    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr] <= sel_data;
    end

endmodule

// File: doc/core_mem_arb.md
Name: core_mem_arb

Overview:
- Sits directly downstream of the core top. Merges its instruction-fetch port (instr_*) and data-access port (data_*) onto a single memory bus port (mem_*) using the same req/gnt/rvalid protocol.
- Arbitrates requests and tracks outstanding transactions in an ID FIFO.
- Routes in-order responses back to the master that issued each one.
- Lets a single-port memory or bus slave serve both core interfaces.

Parameters:
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (1..8); sets the ID FIFO depth.
PRIO_MODE, 0, 0 = fixed priority (data over instr); 1 = round-robin.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch request accepted
instr_addr_i  in  32  fetch address
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch bus error
data_req_i  in  1  data request
data_gnt_o  out  1  data request accepted
data_we_i  in  1  write enable
data_be_i  in  4  byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  write data
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
data_err_o  out  1  data bus error
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted request
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  address
mem_wdata_o  out  32  write data
mem_rvalid_i  in  1  memory response valid (in order)
mem_rdata_i  in  32  response data
mem_err_i  in  1  response error
outstanding_o  out  4  current ID FIFO occupancy
rsp_orphan_o  out  1  one-cycle pulse: rvalid arrived with FIFO empty

Behaviour:
- Reset: FSM enters ARB_IDLE, FIFO empty, rr_last=instr.
- Registered outputs after reset: outstanding_o=0, rsp_orphan_o=0.
- Combinational outputs after reset: mem_req_o=0, both gnt_o=0 and both rvalid_o=0 (valid while rst high and on the first cycle after).
- Reset mid-operation: pending FIFO entries are discarded. Later rvalids count as orphans.
- full = (count==MAX_OUTSTANDING). While full, mem_req_o=0 and no gnt is issued, even if a pop occurs in the same cycle.
- FSM states:
  - ARB_IDLE: select a master from the requesters this cycle.
    - PRIO_MODE 0: data wins.
    - PRIO_MODE 1: the master not equal to rr_last wins on contention; a sole requester always wins.
    - Selected master's signals drive mem_* combinationally; mem_req_o=1.
    - If mem_gnt_i=1: pulse the selected gnt_o in the same cycle, push its ID, update rr_last, stay in ARB_IDLE.
    - If mem_gnt_i=0: go to ARB_WAIT_I or ARB_WAIT_D.
  - ARB_WAIT_I / ARB_WAIT_D: selection is locked to that master. mem_* keeps following it and the other master is not granted.
    - On mem_gnt_i=1: gnt_o, push, rr_last update, return to ARB_IDLE.
    - If the locked master drops req (protocol violation): return to ARB_IDLE with no push.
- Grant latency is 0 cycles; gnt_o = mem_gnt_i & selected & ~full.
- Response routing:
  - On mem_rvalid_i with the FIFO non-empty: rvalid_o is asserted to the head ID's master in the same cycle. rdata/err pass through. Pop.
  - The non-target master's rvalid_o stays 0. rdata_o of both masters may carry mem_rdata_i.
  - On mem_rvalid_i with the FIFO empty: response is dropped and rsp_orphan_o=1 on the next cycle.
- A grant and a response in the same cycle give push+pop, count unchanged. A response for the entry being pushed in that same cycle is impossible (a response needs at least 1 cycle after gnt).
- FIFO pointers wrap modulo MAX_OUTSTANDING. outstanding_o is the registered count, zero-extended.
- mem_we_o/be_o/wdata_o follow the selected master; for instr they are we=0, be=4'hF, wdata=0.

Test Plan:
- Single instr read: instr_req_i=1, addr=0x100, mem_gnt_i=1 → same-cycle instr_gnt_o=1, mem_addr_o=0x100, outstanding_o=1. Response rvalid next cycle with rdata=0xDEADBEEF → instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0, outstanding_o back to 0.
- Contention, PRIO_MODE 0: both masters request every cycle with mem_gnt_i=1 → data granted every cycle, instr starved. PRIO_MODE 1 → grants alternate, first D then I then D (rr_last=instr after reset).
- Stall lock: instr requests with mem_gnt_i=0 for 3 cycles, then data also requests → mem_addr_o stays on instr, data_gnt_o=0. Raising mem_gnt_i gives instr_gnt_o; data is granted the following cycle.
- Full, MAX_OUTSTANDING=2: two grants with no responses → mem_req_o=0 with a request pending. A response pops the head, count goes to 1, and the next request is granted on the following cycle. Responses return to masters in issue order, e.g. D then I.
- Store pass-through: data_we_i=1, be=4'b0011, wdata=0x1234ABCD → mem_* match; response with mem_err_i=1 → data_err_o=1.
- Reset with 2 outstanding, then 1 rvalid → no rvalid_o to either master, rsp_orphan_o pulses 1 cycle, outstanding_o=0.
